fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch front end of the single-issue MIPS core.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request and response interface.
- Buffers returned instructions with their PC and PC+4 in a small FIFO for the decode stage.
- Accepts a one-cycle redirect carrying a branch/jump target from the target-generation logic (adder, shifter, jump-address and sign-extend path), then flushes and refetches from that target.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction buffer entries; legal 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_resp_valid  input  1  response data valid, one pulse per accepted request, at least 1 cycle after acceptance.
- imem_resp_inst  input  32  fetched instruction word.
- redirect_valid  input  1  one-cycle pulse: change PC.
- redirect_target  input  32  new PC; bits [1:0] ignored and forced to 0.
- inst_valid  output  1  buffer head valid.
- inst_ready  input  1  decode consumes head.
- inst_out  output  32  head instruction.
- inst_pc  output  32  head PC.
- inst_pc_plus4  output  32  head PC+4, mod 2^32.

Behaviour:
- Reset (async, asserted):
  - state=START, pc=RESET_PC, buffer empty, stale flag clear.
  - imem_req_valid=0, inst_valid=0.
  - imem_req_addr=RESET_PC; inst_out, inst_pc and inst_pc_plus4 read 0.
- States and transitions:
  - START: emits nothing; goes to ISSUE on the next edge. The first request appears the second cycle after rst deasserts.
  - ISSUE: imem_req_valid = (count < BUF_DEPTH). On accept (valid&ready), latch req_pc=pc, set pc=pc+4 and go to WAIT.
  - WAIT: no request issued. On imem_resp_valid, push {req_pc, imem_resp_inst} and go to ISSUE.
  - WAIT_DROP: an outstanding response is stale. On imem_resp_valid, discard the response and go to ISSUE.
- Outstanding requests: at most one. Buffer space is reserved at issue, so a push never overflows.
- Request address: imem_req_addr = pc. It is held stable while valid and not accepted, except when a redirect occurs; memory must sample the address only on accept.
- Output handshake:
  - inst_valid = buffer non-empty.
  - Head pops on inst_valid&inst_ready.
  - Push and pop in the same cycle are legal and leave count unchanged.
  - Response-to-inst_valid latency is 1 cycle: registered FIFO write, outputs driven from the head.
- PC arithmetic: 32-bit unsigned, wraps, so 32'hFFFF_FFFC+4 = 0. inst_pc_plus4 is computed from the head PC.
- Redirect (takes priority over everything in its cycle):
  - Buffer flushes to count=0, including any pop in that cycle.
  - pc = {redirect_target[31:2], 2'b00}.
  - In ISSUE with no accept: stay in ISSUE; the request address changes next cycle.
  - In ISSUE with an accept in the same cycle: the request is stale; go to WAIT_DROP, and pc = target (not target+4).
  - In WAIT with no response: go to WAIT_DROP.
  - In WAIT with a response in the same cycle: discard the response, go to ISSUE.
  - In WAIT_DROP: remain in WAIT_DROP, or go to ISSUE if the response arrives. pc = target.
  - In START: pc = target; go to ISSUE as normal.
- Flow control: the buffer stays full while inst_ready=0, so imem_req_valid=0 and there is no further fetch.
- Reset mid-operation: any pending response is forgotten immediately. The memory side must also be reset together with this block.

Test Plan:
- Reset, ready=1, 1-cycle memory latency, inst_ready=1 -> requests to 0x0, 0x4, 0x8, in that order; inst_pc 0x0, 0x4, 0x8, in that order; inst_pc_plus4 0x4, 0x8, 0xC; inst_out matches memory words; no gaps beyond 1 idle cycle per fetch.
- inst_ready=0 with BUF_DEPTH=2 -> exactly 2 requests (0x0, 0x4), then imem_req_valid=0. Raise inst_ready -> 0x0 pops first and the next request goes to 0x8.
- Request to 0x8 accepted, then redirect_target=0x100 while in WAIT; response 0xDEADBEEF returns -> 0xDEADBEEF never appears on inst_out, next request is 0x100, inst_pc=0x100.
- Redirect to 0x200 in the same cycle as a request accept, and again with redirect_target=0x203 in the same cycle as a response -> both stale responses dropped, next request is 0x200, low bits masked.
- RESET_PC=32'hFFFF_FFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, then 0x0; inst_pc_plus4 for 0xFFFFFFFC reads 0x0.
- Assert rst during WAIT with a full buffer -> inst_valid=0 and imem_req_valid=0 immediately; first request after release is to RESET_PC, two cycles after rst falls.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time, and
// queues {inst, pc} for decode. A redirect flushes the queue and drops the in-flight fetch.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      inst_buf_q [BUF_DEPTH];
    logic [31:0]      pc_buf_q   [BUF_DEPTH];

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] redirect_pc;
    logic [31:0] head_pc;

    assign redirect_pc    = redirect_target & ~32'h3;
    assign imem_req_valid = (state_q == ST_ISSUE) && (count_q < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign inst_valid     = (count_q != '0);
    // A redirect squashes both the arriving response and any decode pop.
    assign push           = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
    assign pop            = inst_valid && inst_ready && !redirect_valid;

    // Buffer storage is never reset, so the head is masked while empty.
    assign head_pc       = pc_buf_q[rd_ptr_q];
    assign inst_out      = inst_valid ? inst_buf_q[rd_ptr_q] : 32'h0;
    assign inst_pc       = inst_valid ? head_pc : 32'h0;
    assign inst_pc_plus4 = inst_valid ? head_pc + 32'd4 : 32'h0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            ST_START: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid)     state_d = ST_ISSUE;
                else if (redirect_valid) state_d = ST_DROP;
            end
            default: begin
                if (imem_resp_valid) state_d = ST_ISSUE;
            end
        endcase

        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_START;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the data array has no reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_buf_q[wr_ptr_q] <= imem_resp_inst;
            pc_buf_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a latency-configurable memory model plus a
// scoreboard that predicts every fetch address and every {pc, inst, pc+4} delivered to decode.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC  = 32'hFFFF_FFF8;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_inst = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    fetch_sequencer #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    int          compared   = 0;
    int          mismatched = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] acc_log[$];
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] last_acc_addr = 32'h0;
    logic [31:0] last_pop_pc = 32'h0;
    bit          seen_poison = 1'b0;
    bit          acc_seen_n = 1'b0;
    logic [31:0] acc_addr_n = 32'h0;
    logic [31:0] poison_addr = 32'h0000_0001;
    int          mem_lat = 1;
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == poison_addr) ? 32'hDEAD_BEEF : ({a[15:0], a[31:16]} ^ 32'h1357_9BDF);
    endfunction

    // Scoreboard: samples on the falling edge, i.e. the values the next rising edge will act on.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            acc_seen_n = 1'b0;
            if (rst) begin
                exp_q.delete();
                exp_pc = RESET_PC;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    compared++;
                    if (imem_req_addr !== exp_pc) begin
                        mismatched++;
                        $display("FAIL sb_req_addr: got %h expected %h", imem_req_addr, exp_pc);
                    end
                    acc_cnt++;
                    acc_log.push_back(imem_req_addr);
                    last_acc_addr = imem_req_addr;
                    acc_seen_n    = 1'b1;
                    acc_addr_n    = imem_req_addr;
                    if (!redirect_valid) begin
                        exp_q.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
                        exp_pc = exp_pc + 32'd4;
                    end
                end
                if (inst_valid && inst_out === 32'hDEAD_BEEF) seen_poison = 1'b1;
                if (inst_valid && inst_ready && !redirect_valid) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_unexpected_pop: got pc %h inst %h expected no entry", inst_pc, inst_out);
                    end else begin
                        e = exp_q.pop_front();
                        if ({inst_pc, inst_out, inst_pc_plus4} !== {e.pc, e.inst, e.pc + 32'd4}) begin
                            mismatched++;
                            $display("FAIL sb_pop: got pc %h inst %h pc4 %h expected pc %h inst %h pc4 %h",
                                     inst_pc, inst_out, inst_pc_plus4, e.pc, e.inst, e.pc + 32'd4);
                        end
                    end
                    pop_cnt++;
                    last_pop_pc = inst_pc;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    exp_pc = redirect_target & ~32'h3;
                end
            end
        end
    end

    // Memory model: one response per accepted request, mem_lat cycles after the accept.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (rst) begin
                mem_pending = 1'b0;
            end else begin
                if (acc_seen_n) begin
                    mem_pending = 1'b1;
                    mem_cnt     = mem_lat;
                    mem_addr    = acc_addr_n;
                end
                if (mem_pending) begin
                    if (mem_cnt <= 1) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_inst  = mem_word(mem_addr);
                        mem_pending     = 1'b0;
                    end else begin
                        mem_cnt--;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (acc_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok && acc_cnt >= target) ok = 1'b1;
    endtask

    task automatic wait_pop(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pop_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok && pop_cnt >= target) ok = 1'b1;
    endtask

    task automatic restart(input int lat, input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        mem_lat        = lat;
        inst_ready     = rdy;
        imem_req_ready = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        compared++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_valids: got req %b inst %b expected 0 0", imem_req_valid, inst_valid);
        end
        compared++;
        if (imem_req_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
        end
        compared++;
        if ({inst_out, inst_pc, inst_pc_plus4} !== 96'h0) begin
            mismatched++;
            $display("FAIL reset_head: got %h %h %h expected zeros", inst_out, inst_pc, inst_pc_plus4);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL start_idle: got %b expected 0", imem_req_valid);
        end
        step();
        step();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL first_req_held: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int base = acc_cnt;
        int pbase = pop_cnt;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        for (int i = 0; i < 20; i++) step();
        compared++;
        if (acc_cnt - base < 9 || pop_cnt - pbase < 8) begin
            mismatched++;
            $display("FAIL stream_rate: got %0d req %0d pops expected >=9 >=8", acc_cnt - base, pop_cnt - pbase);
        end
        compared++;
        if (acc_log[base] !== RESET_PC || acc_log[base+1] !== RESET_PC + 32'd4 || acc_log[base+2] !== 32'h0) begin
            mismatched++;
            $display("FAIL stream_wrap: got %h %h %h expected fffffff8 fffffffc 00000000",
                     acc_log[base], acc_log[base+1], acc_log[base+2]);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int pbase;
        bit ok;
        restart(1, 1'b0);
        base = acc_cnt;
        for (int i = 0; i < 12; i++) step();
        compared++;
        if (acc_cnt - base != BUF_DEPTH || imem_req_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_stall: got %0d req valid %b expected %0d req valid 0", acc_cnt - base, imem_req_valid, BUF_DEPTH);
        end
        compared++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
            mismatched++;
            $display("FAIL bp_head: got valid %b pc %h expected 1 %h", inst_valid, inst_pc, RESET_PC);
        end
        pbase = pop_cnt;
        inst_ready = 1'b1;
        wait_pop(pbase + 1, 10, ok);
        compared++;
        if (!ok || last_pop_pc !== RESET_PC) begin
            mismatched++;
            $display("FAIL bp_first_pop: got ok %b pc %h expected 1 %h", ok, last_pop_pc, RESET_PC);
        end
        wait_acc(base + 3, 10, ok);
        compared++;
        if (!ok || last_acc_addr !== RESET_PC + 32'd8) begin
            mismatched++;
            $display("FAIL bp_resume_addr: got ok %b addr %h expected 1 %h", ok, last_acc_addr, RESET_PC + 32'd8);
        end
    endtask

    task automatic test_redirect_wait();
        int base;
        int pbase;
        bit ok;
        poison_addr = RESET_PC + 32'd8;
        seen_poison = 1'b0;
        restart(3, 1'b1);
        base = acc_cnt;
        wait_acc(base + 3, 40, ok);
        compared++;
        if (!ok || last_acc_addr !== poison_addr) begin
            mismatched++;
            $display("FAIL rw_setup: got ok %b addr %h expected 1 %h", ok, last_acc_addr, poison_addr);
        end
        pbase = pop_cnt;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        wait_acc(base + 4, 20, ok);
        compared++;
        if (!ok || last_acc_addr !== 32'h100) begin
            mismatched++;
            $display("FAIL rw_next_req: got ok %b addr %h expected 1 00000100", ok, last_acc_addr);
        end
        wait_pop(pbase + 1, 20, ok);
        compared++;
        if (!ok || last_pop_pc !== 32'h100 || seen_poison) begin
            mismatched++;
            $display("FAIL rw_pop: got ok %b pc %h poison %b expected 1 00000100 0", ok, last_pop_pc, seen_poison);
        end
        poison_addr = 32'h0000_0001;
    endtask

    task automatic test_redirect_accept();
        int base;
        int pbase;
        bit ok;
        restart(1, 1'b1);
        base = acc_cnt;
        wait_acc(base + 1, 10, ok);
        step();
        compared++;
        if (!ok || imem_req_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL ra_setup: got ok %b valid %b expected 1 1", ok, imem_req_valid);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        step();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            mismatched++;
            $display("FAIL ra_refetch: got valid %b addr %h expected 1 00000200", imem_req_valid, imem_req_addr);
        end
        step();
        compared++;
        if (imem_resp_valid !== 1'b1 || last_acc_addr !== 32'h200) begin
            mismatched++;
            $display("FAIL rr_setup: got resp %b addr %h expected 1 00000200", imem_resp_valid, last_acc_addr);
        end
        base  = acc_cnt;
        pbase = pop_cnt;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        wait_acc(base + 1, 10, ok);
        compared++;
        if (!ok || last_acc_addr !== 32'h200) begin
            mismatched++;
            $display("FAIL rr_masked_addr: got ok %b addr %h expected 1 00000200", ok, last_acc_addr);
        end
        wait_pop(pbase + 1, 10, ok);
        compared++;
        if (!ok || last_pop_pc !== 32'h200) begin
            mismatched++;
            $display("FAIL rr_pop: got ok %b pc %h expected 1 00000200", ok, last_pop_pc);
        end
    endtask

    task automatic test_reset_midop();
        int base;
        int pbase;
        bit ok;
        restart(6, 1'b0);
        base = acc_cnt;
        wait_acc(base + 2, 40, ok);
        compared++;
        if (!ok || inst_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL mr_setup: got ok %b inst_valid %b expected 1 1", ok, inst_valid);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({inst_valid, imem_req_valid} !== 2'b00 || imem_req_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL mr_async: got inst %b req %b addr %h expected 0 0 %h", inst_valid, imem_req_valid, imem_req_addr, RESET_PC);
        end
        step();
        step();
        mem_lat    = 1;
        inst_ready = 1'b1;
        pbase      = pop_cnt;
        rst        = 1'b0;
        #1;
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mr_start: got %b expected 0", imem_req_valid);
        end
        step();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL mr_first_req: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        wait_pop(pbase + 1, 10, ok);
        compared++;
        if (!ok || last_pop_pc !== RESET_PC) begin
            mismatched++;
            $display("FAIL mr_first_pop: got ok %b pc %h expected 1 %h", ok, last_pop_pc, RESET_PC);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_accept();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
